// File: rtl/distortion_core.sv
// ---------------------------------------------------------------------------
// distortion_core
//   Three-stage streaming distortion datapath. It takes signed 16-bit audio
//   samples on a valid/ready stream and applies one of four modes using the
//   gain, threshold and mode settings captured with each sample. A single
//   advance enable stalls the whole pipeline when the output is held.
//
//   Build option: define DISTORTION_SOFTCLIP_EN to include the mode-2 soft
//   clipper. Without it, mode 2 passes samples through like mode 0.
//
// Ports
//   CLK          system clock, rising edge
//   RST_N        asynchronous active-low reset
//   gain         signed gain (values below 1 act as 1)
//   threshold    signed clip threshold for mode 3
//   mode         0 bypass, 1 gain+saturate, 2 soft clip, 3 threshold clip
//   in_sample    signed input sample
//   in_valid     input sample present
//   in_ready     input accepted this cycle
//   out_sample   signed processed sample
//   out_valid    out_sample valid
//   out_ready    downstream accepts out_sample
//   out_clipped  limiting altered this output sample
//   clip_count   saturating count of clipped samples transferred out
// ---------------------------------------------------------------------------
module distortion_core (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic signed [15:0] gain,
  input  logic signed [31:0] threshold,
  input  logic        [1:0]  mode,
  input  logic signed [15:0] in_sample,
  input  logic               in_valid,
  output logic               in_ready,
  output logic signed [15:0] out_sample,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_clipped,
  output logic        [15:0] clip_count
);

  // Saturate a 32-bit product into 16 bits; MSB of the result flags clipping.
  function automatic logic [16:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767)       return {1'b1, 16'h7FFF};
    else if (v < -32'sd32768) return {1'b1, 16'h8000};
    else                      return {1'b0, v[15:0]};
  endfunction

  // Threshold limited to the representable positive range.
  function automatic logic signed [15:0] clamp_thr(input logic signed [31:0] t);
    if (t < 32'sd0)          return 16'sd0;
    else if (t > 32'sd32767) return 16'sh7FFF;
    else                     return t[15:0];
  endfunction

  // Symmetric limit of x to [-t, t], t already non-negative.
  function automatic logic signed [15:0] limit(input logic signed [15:0] x,
                                               input logic signed [15:0] t);
    if (x > t)       return t;
    else if (x < -t) return -t;
    else             return x;
  endfunction

`ifdef DISTORTION_SOFTCLIP_EN
  // Halve the magnitude above 16384. Magnitude is 17 bits so -32768 is exact.
  function automatic logic signed [15:0] soft_clip(input logic signed [15:0] x);
    logic [16:0] ax;
    logic [15:0] mag;
    ax = x[15] ? (~{1'b1, x} + 17'd1) : {1'b0, x};
    if (ax <= 17'd16384) return x;
    mag = 16'd16384 + 16'((ax - 17'd16384) >> 1);
    return x[15] ? -mag : mag;
  endfunction
`endif

  logic adv;

  logic               vld_p1_q, vld_p1_d;
  logic signed [15:0] sample_p1_q, sample_p1_d;
  logic signed [15:0] gain_p1_q, gain_p1_d;
  logic signed [31:0] thr_p1_q, thr_p1_d;
  logic        [1:0]  mode_p1_q, mode_p1_d;

  logic               vld_p2_q, vld_p2_d;
  logic signed [15:0] sample_p2_q, sample_p2_d;
  logic signed [31:0] raw_p2_q, raw_p2_d;
  logic signed [15:0] t_p2_q, t_p2_d;
  logic        [1:0]  mode_p2_q, mode_p2_d;

  logic               vld_p3_q, vld_p3_d;
  logic signed [15:0] sample_p3_q, sample_p3_d;
  logic               clipped_p3_q, clipped_p3_d;

  logic        [15:0] clip_count_q, clip_count_d;

  logic signed [15:0] geff_p1;
  logic signed [31:0] x_ext_p1, g_ext_p1;
  logic        [16:0] sat_p2;

  assign adv         = !vld_p3_q || out_ready;
  assign in_ready    = adv;
  assign out_valid   = vld_p3_q;
  assign out_sample  = sample_p3_q;
  assign out_clipped = clipped_p3_q;
  assign clip_count  = clip_count_q;

  always_comb begin
    // Stage 1: snapshot sample and settings
    vld_p1_d    = in_valid && adv;
    sample_p1_d = in_sample;
    gain_p1_d   = gain;
    thr_p1_d    = threshold;
    mode_p1_d   = mode;

    // Stage 2: raw result before limiting
    geff_p1  = (gain_p1_q < 16'sd1) ? 16'sd1 : gain_p1_q;
    x_ext_p1 = {{16{sample_p1_q[15]}}, sample_p1_q};
    g_ext_p1 = {{16{geff_p1[15]}}, geff_p1};
    vld_p2_d    = vld_p1_q;
    sample_p2_d = sample_p1_q;
    mode_p2_d   = mode_p1_q;
    t_p2_d      = clamp_thr(thr_p1_q);
    raw_p2_d    = x_ext_p1;
    case (mode_p1_q)
      2'd1: raw_p2_d = x_ext_p1 * g_ext_p1;
`ifdef DISTORTION_SOFTCLIP_EN
      2'd2: raw_p2_d = {{16{1'b0}}, soft_clip(sample_p1_q)};
`endif
      default: raw_p2_d = x_ext_p1;
    endcase

    // Stage 3: limit and flag clipping
    sat_p2       = sat16(raw_p2_q);
    vld_p3_d     = vld_p2_q;
    sample_p3_d  = sample_p2_q;
    clipped_p3_d = 1'b0;
    case (mode_p2_q)
      2'd1: begin
        sample_p3_d  = sat_p2[15:0];
        clipped_p3_d = sat_p2[16];
      end
`ifdef DISTORTION_SOFTCLIP_EN
      2'd2: begin
        sample_p3_d  = raw_p2_q[15:0];
        clipped_p3_d = (raw_p2_q[15:0] != sample_p2_q);
      end
`endif
      2'd3: begin
        sample_p3_d  = limit(sample_p2_q, t_p2_q);
        clipped_p3_d = (sample_p3_d != sample_p2_q);
      end
      default: begin
        sample_p3_d  = sample_p2_q;
        clipped_p3_d = 1'b0;
      end
    endcase

    clip_count_d = clip_count_q;
    if (vld_p3_q && out_ready && clipped_p3_q && (clip_count_q != 16'hFFFF))
      clip_count_d = clip_count_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_p1_q     <= 1'b0;
      vld_p2_q     <= 1'b0;
      vld_p3_q     <= 1'b0;
      sample_p3_q  <= '0;
      clipped_p3_q <= 1'b0;
      clip_count_q <= '0;
    end else begin
      clip_count_q <= clip_count_d;
      if (adv) begin
        vld_p1_q     <= vld_p1_d;
        vld_p2_q     <= vld_p2_d;
        vld_p3_q     <= vld_p3_d;
        sample_p3_q  <= sample_p3_d;
        clipped_p3_q <= clipped_p3_d;
      end
    end
  end

  // Internal data stages carry no reset; their valids gate them.
  always_ff @(posedge CLK) begin
    if (adv) begin
      sample_p1_q <= sample_p1_d;
      gain_p1_q   <= gain_p1_d;
      thr_p1_q    <= thr_p1_d;
      mode_p1_q   <= mode_p1_d;
      sample_p2_q <= sample_p2_d;
      raw_p2_q    <= raw_p2_d;
      t_p2_q      <= t_p2_d;
      mode_p2_q   <= mode_p2_d;
    end
  end

endmodule

// File: tb/tb_distortion_core.sv
// ---------------------------------------------------------------------------
// tb_distortion_core
//   Scoreboard bench for distortion_core. Accepted samples push the reference
//   result into a queue; the output monitor pops and compares on every
//   transfer, tracks hold stability under back-pressure and models the
//   saturating clip counter.
// ---------------------------------------------------------------------------
module tb_distortion_core;

  logic               CLK = 1'b0;
  logic               RST_N;
  logic signed [15:0] gain;
  logic signed [31:0] threshold;
  logic        [1:0]  mode;
  logic signed [15:0] in_sample;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] out_sample;
  logic               out_valid;
  logic               out_ready;
  logic               out_clipped;
  logic        [15:0] clip_count;

  distortion_core dut (
    .CLK(CLK), .RST_N(RST_N), .gain(gain), .threshold(threshold), .mode(mode),
    .in_sample(in_sample), .in_valid(in_valid), .in_ready(in_ready),
    .out_sample(out_sample), .out_valid(out_valid), .out_ready(out_ready),
    .out_clipped(out_clipped), .clip_count(clip_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int y;
    int c;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   model_cnt = 0;
  logic rand_rdy = 1'b0;
  logic held_vld = 1'b0;
  int   held_s, held_c;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: mode rules in plain integer arithmetic.
  function automatic exp_t model(input int x, input int g, input int thr, input int m);
    exp_t e;
    int geff, p, ax, mg, t;
    e.y = x;
    e.c = 0;
    case (m)
      1: begin
        geff = (g < 1) ? 1 : g;
        p = x * geff;
        if (p > 32767) begin e.y = 32767; e.c = 1; end
        else if (p < -32768) begin e.y = -32768; e.c = 1; end
        else e.y = p;
      end
      2: begin
`ifdef DISTORTION_SOFTCLIP_EN
        ax = (x < 0) ? -x : x;
        if (ax > 16384) begin
          mg = 16384 + (ax - 16384) / 2;
          e.y = (x < 0) ? -mg : mg;
          e.c = 1;
        end
`endif
      end
      3: begin
        t = (thr < 0) ? 0 : ((thr > 32767) ? 32767 : thr);
        if (x > t) e.y = t;
        else if (x < -t) e.y = -t;
        e.c = (e.y != x) ? 1 : 0;
      end
      default: ;
    endcase
    return e;
  endfunction

  // Monitor + scoreboard owner
  always @(negedge CLK) begin
    exp_t e;
    if (!RST_N) begin
      sb_q.delete();
      model_cnt = 0;
      held_vld  = 1'b0;
    end else begin
      if (held_vld) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_sample", int'(out_sample), held_s);
        check("hold_clipped", int'(out_clipped), held_c);
      end
      if (out_valid && !out_ready) check("stall_in_ready", int'(in_ready), 0);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_output: got sample %0d with nothing expected", out_sample);
        end else begin
          e = sb_q.pop_front();
          check("out_sample", int'(out_sample), e.y);
          check("out_clipped", int'(out_clipped), e.c);
          check("clip_count", int'(clip_count), model_cnt);
          if (e.c != 0 && model_cnt < 65535) model_cnt++;
        end
      end
      held_vld = out_valid && !out_ready;
      held_s   = int'(out_sample);
      held_c   = int'(out_clipped);
      if (in_valid && in_ready)
        sb_q.push_back(model(int'(in_sample), int'(gain), int'(threshold), int'(mode)));
    end
  end

  // Random back-pressure source
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Entered and left just after a rising edge.
  task automatic send(input int x, input int g, input int thr, input int m);
    int w;
    in_sample = 16'(x);
    gain      = 16'(g);
    threshold = thr;
    mode      = 2'(m);
    in_valid  = 1'b1;
    w = 0;
    @(negedge CLK);
    while (!in_ready && w < 1000) begin
      @(negedge CLK);
      w++;
    end
    if (w >= 1000) check("accept_timeout", w, 0);
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < 200) begin
      @(negedge CLK);
      w++;
    end
    check("drain_empty", sb_q.size(), 0);
    idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0; in_valid = 1'b0; in_sample = '0; gain = 16'sd1;
    threshold = 32'sd0; mode = 2'd0; out_ready = 1'b1;
    #12;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_sample", int'(out_sample), 0);
    check("rst_out_clipped", int'(out_clipped), 0);
    check("rst_clip_count", int'(clip_count), 0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(negedge CLK);
    check("rst_in_ready", int'(in_ready), 1);
    idle();

    // Bypass
    send(100, 1, 0, 0); send(-32768, 1, 0, 0); send(32767, 1, 0, 0);
    drain();

    // Gain + saturate, then gain 0 acting as 1
    send(1000, 10, 0, 1); send(4000, 10, 0, 1); send(-4000, 10, 0, 1);
    send(500, 0, 0, 1);
    drain();
    check("clip_count_after_gain", int'(clip_count), 2);

    // Threshold clip, including out-of-range thresholds
    send(999, 1, 1000, 3); send(1500, 1, 1000, 3); send(-2000, 1, 1000, 3);
    send(32767, 1, 40000, 3); send(1234, 1, -5, 3); send(-77, 1, -5, 3);
    drain();

    // Soft clip (or pass-through without the option)
    send(16384, 1, 0, 2); send(20000, 1, 0, 2); send(-32768, 1, 0, 2);
    send(16385, 1, 0, 2);
    drain();

    // Output held for five cycles while input keeps offering samples
    fork
      begin
        for (int i = 0; i < 8; i++) send(i * 111 - 300, 3, 200, i % 4);
      end
      begin
        @(posedge CLK); #1;
        out_ready = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Randomized traffic with random back-pressure and parameter changes
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) idle();
      send(int'($urandom_range(0, 65535)) - 32768,
           int'($urandom_range(0, 70)) - 5,
           ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 100000)) - 50000
                                       : int'($urandom_range(0, 33000)),
           int'($urandom_range(0, 3)));
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset with samples in flight
    send(4000, 10, 0, 1); send(5000, 10, 0, 1); send(100, 10, 0, 1);
    RST_N = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_clip_count", int'(clip_count), 0);
    repeat (2) idle();
    RST_N = 1'b1;
    idle();

    // First sample after reset: output in the third cycle after acceptance
    in_sample = 16'sd42; gain = 16'sd1; threshold = 32'sd0; mode = 2'd0;
    in_valid = 1'b1;
    @(negedge CLK);
    check("lat_in_ready", int'(in_ready), 1);
    @(posedge CLK); #1;
    in_valid = 1'b0;
    @(negedge CLK);
    check("lat_cycle1", int'(out_valid), 0);
    @(negedge CLK);
    check("lat_cycle2", int'(out_valid), 0);
    @(negedge CLK);
    check("lat_cycle3", int'(out_valid), 1);
    check("lat_sample", int'(out_sample), 42);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
